// File: rtl/cmm_adder_arbiter.sv
// cmm_adder_arbiter: round-robin sharing of one complex matrix adder among NUM_REQ AXI-Stream requesters.
// Packets keep the grant up to MAX_BURST beats; results return tagged with the requester index.
module complex_matrix_adder_parallel #(
   parameter int MAT_WIDTH = 4,
   parameter int MAT_HEIGHT = 4,
   parameter int ELEMENT_SIZE = 16,
   localparam int DW = MAT_WIDTH * MAT_HEIGHT * ELEMENT_SIZE
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [DW-1:0] s_axis_a_tdata,
   input  logic          s_axis_a_tuser,
   input  logic          s_axis_a_tvalid,
   input  logic          s_axis_a_tlast,
   output logic          s_axis_a_tready,
   input  logic [DW-1:0] s_axis_b_tdata,
   input  logic          s_axis_b_tuser,
   input  logic          s_axis_b_tvalid,
   input  logic          s_axis_b_tlast,
   output logic          s_axis_b_tready,
   output logic [DW-1:0] m_axis_tdata,
   output logic [1:0]    m_axis_tuser,
   output logic          m_axis_tvalid,
   output logic          m_axis_tlast,
   input  logic          m_axis_tready
);
   localparam int HW = ELEMENT_SIZE / 2;
   logic          rdy;
   logic          ld;
   logic [DW-1:0] sum;
   // Real and imag halves add independently so no carry crosses between them.
   for (genvar e = 0; e < MAT_WIDTH * MAT_HEIGHT; e++) begin : g_el
      assign sum[e*ELEMENT_SIZE +: ELEMENT_SIZE] = {
         s_axis_a_tdata[e*ELEMENT_SIZE+HW +: HW] + s_axis_b_tdata[e*ELEMENT_SIZE+HW +: HW],
         s_axis_a_tdata[e*ELEMENT_SIZE +: HW] + s_axis_b_tdata[e*ELEMENT_SIZE +: HW]};
   end
   always_comb begin
      s_axis_a_tready = rdy & (~m_axis_tvalid | m_axis_tready);
      s_axis_b_tready = s_axis_a_tready;
      ld = s_axis_a_tvalid & s_axis_b_tvalid & s_axis_a_tready;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rdy <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tuser <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast <= 1'b0;
      end else begin
         rdy <= 1'b1;
         if (ld) begin
            m_axis_tdata <= sum;
            m_axis_tuser <= {s_axis_a_tuser, s_axis_b_tuser};
            m_axis_tlast <= s_axis_a_tlast | s_axis_b_tlast;
            m_axis_tvalid <= 1'b1;
         end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      end
endmodule

module cmm_adder_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int MAT_WIDTH = 4,
   parameter int MAT_HEIGHT = 4,
   parameter int ELEMENT_SIZE = 16,
   parameter int MAX_BURST = 8,
   localparam int DW = MAT_WIDTH * MAT_HEIGHT * ELEMENT_SIZE,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ*DW-1:0] s_axis_a_tdata,
   input  logic [NUM_REQ*DW-1:0] s_axis_b_tdata,
   input  logic [2*NUM_REQ-1:0]  s_axis_tuser,
   input  logic [NUM_REQ-1:0]    s_axis_tvalid,
   input  logic [NUM_REQ-1:0]    s_axis_tlast,
   output logic [NUM_REQ-1:0]    s_axis_tready,
   output logic [DW-1:0]         m_axis_tdata,
   output logic [1:0]            m_axis_tuser,
   output logic                  m_axis_tlast,
   output logic [IW-1:0]         m_axis_tdest,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);
   localparam int BW = $clog2(MAX_BURST + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t        state, nxt;
   logic [IW-1:0] g, rr_ptr, pick, nxt_rr;
   logic          found;
   logic [BW-1:0] burst_cnt;
   logic          lock;
   logic [DW-1:0] ad_a_data, ad_b_data, ad_m_data;
   logic          ad_a_user, ad_b_user, ad_last, ad_valid;
   logic          ad_a_rdy, ad_b_rdy, ad_m_valid, ad_m_last, hs;
   logic [1:0]    ad_m_user;

   complex_matrix_adder_parallel #(
      .MAT_WIDTH(MAT_WIDTH),
      .MAT_HEIGHT(MAT_HEIGHT),
      .ELEMENT_SIZE(ELEMENT_SIZE)
   ) u_add (
      .clk(clk),
      .reset_n(reset_n),
      .s_axis_a_tdata(ad_a_data),
      .s_axis_a_tuser(ad_a_user),
      .s_axis_a_tvalid(ad_valid),
      .s_axis_a_tlast(ad_last),
      .s_axis_a_tready(ad_a_rdy),
      .s_axis_b_tdata(ad_b_data),
      .s_axis_b_tuser(ad_b_user),
      .s_axis_b_tvalid(ad_valid),
      .s_axis_b_tlast(ad_last),
      .s_axis_b_tready(ad_b_rdy),
      .m_axis_tdata(ad_m_data),
      .m_axis_tuser(ad_m_user),
      .m_axis_tvalid(ad_m_valid),
      .m_axis_tlast(ad_m_last),
      .m_axis_tready(1'b1)
   );

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      pick = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (!found && s_axis_tvalid[IW'((int'(rr_ptr) + i) % NUM_REQ)]) begin
            pick = IW'((int'(rr_ptr) + i) % NUM_REQ);
            found = 1'b1;
         end
   end

   always_comb begin
      ad_a_data = s_axis_a_tdata[int'(g)*DW +: DW];
      ad_b_data = s_axis_b_tdata[int'(g)*DW +: DW];
      ad_a_user = s_axis_tuser[{g, 1'b1}];
      ad_b_user = s_axis_tuser[{g, 1'b0}];
      ad_last = s_axis_tlast[g];
      ad_valid = (state == ISSUE) & s_axis_tvalid[g];
      s_axis_tready = '0;
      if (state == ISSUE) s_axis_tready[g] = ad_a_rdy & ad_b_rdy;
      hs = ad_valid & ad_a_rdy & ad_b_rdy;
      nxt_rr = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = found ? ISSUE : IDLE;
         ISSUE:   nxt = hs ? WAIT : ISSUE;
         WAIT:    nxt = ad_m_valid ? RESP : WAIT;
         RESP:    nxt = m_axis_tready ? (lock ? ISSUE : IDLE) : RESP;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= nxt;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         g <= '0;
         rr_ptr <= '0;
         burst_cnt <= '0;
         lock <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tuser <= '0;
         m_axis_tlast <= 1'b0;
         m_axis_tdest <= '0;
         m_axis_tvalid <= 1'b0;
      end else begin
         if (state == IDLE && found) begin
            g <= pick;
            burst_cnt <= '0;
         end
         if (hs) begin
            burst_cnt <= burst_cnt + 1'b1;
            lock <= ~s_axis_tlast[g] & (32'(burst_cnt) + 1 < MAX_BURST);
         end
         if (state == WAIT && ad_m_valid) begin
            m_axis_tdata <= ad_m_data;
            m_axis_tuser <= ad_m_user;
            m_axis_tlast <= ad_m_last;
            m_axis_tdest <= g;
            m_axis_tvalid <= 1'b1;
         end
         if (state == RESP && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            if (!lock) rr_ptr <= nxt_rr;
         end
      end
endmodule

// File: tb/tb_cmm_adder_arbiter.sv
// tb_cmm_adder_arbiter: directed requester traffic with a queued scoreboard checked by a forked monitor.
module tb_cmm_adder_arbiter;
   localparam int NR = 4;
   localparam int DW = 256;
   localparam int IW = 2;
   typedef struct packed {logic [DW-1:0] a; logic [DW-1:0] b; logic [1:0] user; logic last;} beat_t;
   typedef struct packed {logic [DW-1:0] sum; logic [1:0] user; logic last; logic [IW-1:0] dest;} exp_t;

   logic             clk;
   logic             reset_n;
   logic [NR*DW-1:0] s_axis_a_tdata, s_axis_b_tdata;
   logic [2*NR-1:0]  s_axis_tuser;
   logic [NR-1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [DW-1:0]    m_axis_tdata;
   logic [1:0]       m_axis_tuser;
   logic             m_axis_tlast;
   logic [IW-1:0]    m_axis_tdest;
   logic             m_axis_tvalid;
   logic             m_axis_tready;

   beat_t         rq[NR][$];
   exp_t          exp_q[$];
   logic [NR-1:0] hs_v;
   int            errors = 0;
   int            checks = 0;

   cmm_adder_arbiter dut (
      .clk(clk),
      .reset_n(reset_n),
      .s_axis_a_tdata(s_axis_a_tdata),
      .s_axis_b_tdata(s_axis_b_tdata),
      .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast),
      .m_axis_tdest(m_axis_tdest),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic drive();
      for (int r = 0; r < NR; r++)
         if (rq[r].size() != 0) begin
            s_axis_tvalid[r] = 1'b1;
            s_axis_a_tdata[r*DW +: DW] = rq[r][0].a;
            s_axis_b_tdata[r*DW +: DW] = rq[r][0].b;
            s_axis_tuser[2*r +: 2] = rq[r][0].user;
            s_axis_tlast[r] = rq[r][0].last;
         end else s_axis_tvalid[r] = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      hs_v = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) if (hs_v[r]) rq[r].delete(0);
      drive();
   endtask

   task automatic add(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] u, input logic l);
      beat_t bt;
      bt.a = a;
      bt.b = b;
      bt.user = u;
      bt.last = l;
      rq[r].push_back(bt);
      drive();
   endtask

   task automatic expect_beat(input logic [DW-1:0] s, input logic [1:0] u, input logic l, input int d);
      exp_t e;
      e.sum = s;
      e.user = u;
      e.last = l;
      e.dest = IW'(d);
      exp_q.push_back(e);
   endtask

   function automatic bit busy();
      busy = exp_q.size() != 0;
      for (int r = 0; r < NR; r++) if (rq[r].size() != 0) busy = 1'b1;
   endfunction

   task automatic wait_drain(input string name);
      int n = 0;
      while (busy() && n < 300) begin
         tick();
         n++;
      end
      if (busy()) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout with %0d responses outstanding, required 0", name, exp_q.size());
         exp_q.delete();
         for (int r = 0; r < NR; r++) rq[r].delete();
         drive();
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            check("tready_onehot", DW'($countones(s_axis_tready) <= 1), DW'(1));
            if (m_axis_tvalid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got dest=%0d data=%h, required no beat", m_axis_tdest, m_axis_tdata);
               end else begin
                  e = exp_q[0];
                  check("tdata", m_axis_tdata, e.sum);
                  check("tuser", DW'(m_axis_tuser), DW'(e.user));
                  check("tlast", DW'(m_axis_tlast), DW'(e.last));
                  check("tdest", DW'(m_axis_tdest), DW'(e.dest));
                  check("s_ready_in_resp", DW'(s_axis_tready), DW'(0));
                  if (m_axis_tready) exp_q.delete(0);
               end
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_s_ready"}, DW'(s_axis_tready), DW'(0));
      check({name, "_m_valid"}, DW'(m_axis_tvalid), DW'(0));
      check({name, "_m_data"}, m_axis_tdata, DW'(0));
      check({name, "_m_user"}, DW'(m_axis_tuser), DW'(0));
      check({name, "_m_last"}, DW'(m_axis_tlast), DW'(0));
      check({name, "_m_dest"}, DW'(m_axis_tdest), DW'(0));
   endtask

   task automatic run_tests();
      int n;
      reset_n = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_a_tdata = '0;
      s_axis_b_tdata = '0;
      s_axis_tuser = '0;
      s_axis_tvalid = '0;
      s_axis_tlast = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      // single requester and its 3-cycle latency
      add(2, {16{16'h0305}}, {16{16'h0102}}, 2'b10, 1'b1);
      expect_beat({16{16'h0407}}, 2'b10, 1'b1, 2);
      tick();
      tick();
      check("latency_before", DW'(m_axis_tvalid), DW'(0));
      tick();
      check("latency_at_3", DW'(m_axis_tvalid), DW'(1));
      wait_drain("single");
      // per-half wrap with no carry between halves
      add(2, {16{16'hFF80}}, {16{16'h0180}}, 2'b01, 1'b1);
      expect_beat({16{16'h0000}}, 2'b01, 1'b1, 2);
      wait_drain("wrap");
      add(3, {8{16'h7F01, 16'h00FF}}, {8{16'h0102, 16'h8001}}, 2'b11, 1'b1);
      expect_beat({8{16'h8003, 16'h8000}}, 2'b11, 1'b1, 3);
      wait_drain("mixed");
      // round robin, pointer at 0
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < NR; r++) begin
            add(r, {16{16'((r + 1) << 12)}}, {16{16'(r + 1)}}, 2'(r), 1'b1);
            expect_beat({16{16'(((r + 1) << 12) | (r + 1))}}, 2'(r), 1'b1, r);
         end
      wait_drain("round_robin");
      add(0, {16{16'h0A0A}}, {16{16'h0101}}, 2'b00, 1'b1);
      expect_beat({16{16'h0B0B}}, 2'b00, 1'b1, 0);
      wait_drain("pointer_to_1");
      // three-beat packet from 1 holds the grant over a waiting 0
      add(1, {16{16'h1111}}, {16{16'h0101}}, 2'b10, 1'b0);
      add(1, {16{16'h2222}}, {16{16'h0101}}, 2'b10, 1'b0);
      add(1, {16{16'h3333}}, {16{16'h0101}}, 2'b10, 1'b1);
      add(0, {16{16'h0505}}, {16{16'h0505}}, 2'b01, 1'b1);
      expect_beat({16{16'h1212}}, 2'b10, 1'b0, 1);
      expect_beat({16{16'h2323}}, 2'b10, 1'b0, 1);
      expect_beat({16{16'h3434}}, 2'b10, 1'b1, 1);
      expect_beat({16{16'h0A0A}}, 2'b01, 1'b1, 0);
      wait_drain("burst_lock");
      // 12-beat packet is cut after 8 beats so requester 2 gets a turn
      for (int k = 0; k < 12; k++) add(1, {16{8'(k), 8'(k)}}, {16{16'h0101}}, 2'b10, k == 11);
      add(2, {16{16'h4000}}, {16{16'h0004}}, 2'b00, 1'b1);
      for (int k = 0; k < 8; k++) expect_beat({16{8'(k + 1), 8'(k + 1)}}, 2'b10, 1'b0, 1);
      expect_beat({16{16'h4004}}, 2'b00, 1'b1, 2);
      for (int k = 8; k < 12; k++) expect_beat({16{8'(k + 1), 8'(k + 1)}}, 2'b10, k == 11, 1);
      wait_drain("burst_cap");
      // backpressure in RESP on a locked two-beat packet
      m_axis_tready = 1'b0;
      add(3, {16{16'h1234}}, {16{16'h1111}}, 2'b01, 1'b0);
      add(3, {16{16'h0F0F}}, {16{16'h0101}}, 2'b10, 1'b1);
      expect_beat({16{16'h2345}}, 2'b01, 1'b0, 3);
      expect_beat({16{16'h1010}}, 2'b10, 1'b1, 3);
      n = 0;
      while (!m_axis_tvalid && n < 20) begin
         tick();
         n++;
      end
      check("bp_reach_resp", DW'(m_axis_tvalid), DW'(1));
      repeat (5) begin
         check("bp_s_ready", DW'(s_axis_tready), DW'(0));
         check("bp_valid", DW'(m_axis_tvalid), DW'(1));
         tick();
      end
      m_axis_tready = 1'b1;
      tick();
      check("bp_next_issue", DW'(s_axis_tready), DW'(4'b1000));
      wait_drain("backpressure");
      // reset while in WAIT drops the beat and clears the pointer
      add(0, {16{16'h2020}}, {16{16'h0303}}, 2'b01, 1'b1);
      expect_beat({16{16'h2323}}, 2'b01, 1'b1, 0);
      wait_drain("pointer_to_1b");
      add(2, {16{16'h7777}}, {16{16'h1111}}, 2'b11, 1'b1);
      n = 0;
      hs_v = '0;
      while (!hs_v[2] && n < 20) begin
         tick();
         n++;
      end
      check("reset_reach_wait", DW'(hs_v[2]), DW'(1));
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      add(1, {16{16'h0001}}, {16{16'h0001}}, 2'b10, 1'b1);
      add(0, {16{16'h0100}}, {16{16'h0100}}, 2'b01, 1'b1);
      expect_beat({16{16'h0200}}, 2'b01, 1'b1, 0);
      expect_beat({16{16'h0002}}, 2'b10, 1'b1, 1);
      wait_drain("after_reset");
      repeat (6) tick();
   endtask

   initial begin
      fork
         monitor();
         run_tests();
      join_any
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
